// File: rtl/mac_array_os.sv
// Output-stationary matrix-vector MAC array: accumulates a programmable number of
// handshaked activation beats against per-row weights, then presents saturated results.
module mac_array_os #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ACC_WIDTH  = 48,
  parameter int OUT_WIDTH  = 32,
  parameter int KLEN_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_i,
  input  logic [KLEN_WIDTH-1:0]              k_len_i,
  input  logic                               signed_i,
  input  logic                               abort_i,
  output logic                               busy_o,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [DATA_WIDTH*COLS-1:0]         a_i,
  input  logic [DATA_WIDTH*ROWS*COLS-1:0]    w_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [OUT_WIDTH*ROWS-1:0]          out_data_o,
  output logic [ROWS-1:0]                    out_sat_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}} >> (ACC_WIDTH-OUT_WIDTH);
  localparam logic [ACC_WIDTH-1:0] SMIN = ~SMAX;
  localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}} >> (ACC_WIDTH-OUT_WIDTH);

  state_t                state, state_nxt;
  logic [KLEN_WIDTH-1:0] cnt;
  logic                  mode_signed;
  logic [ACC_WIDTH-1:0]  acc      [ROWS];
  logic [ACC_WIDTH-1:0]  beat_sum [ROWS];

  logic start_fire, beat_fire, abort_fire;

  assign start_fire = (state == IDLE)  & start_i & ~abort_i;
  assign beat_fire  = (state == ACCUM) & in_valid_i & ~abort_i;
  assign abort_fire = (state != IDLE)  & abort_i;

  assign busy_o      = (state == ACCUM) | (state == DONE);
  assign in_ready_o  = (state == ACCUM) & ~abort_i;
  assign out_valid_o = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_fire) state_nxt = (k_len_i == '0) ? DONE : ACCUM;
      ACCUM:   if (abort_i) state_nxt = IDLE;
               else if (in_valid_i && cnt == KLEN_WIDTH'(1)) state_nxt = DONE;
      DONE:    if (abort_i || out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands get one extra bit carrying the mode-dependent sign, so a single
  // signed multiplier covers both signed and unsigned jobs.
  always_comb begin
    logic signed [DATA_WIDTH:0]     ax, wx;
    logic signed [2*DATA_WIDTH+1:0] prod;
    ax   = '0;
    wx   = '0;
    prod = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      beat_sum[r] = '0;
      for (int unsigned c = 0; c < COLS; c++) begin
        ax = {mode_signed & a_i[c*DATA_WIDTH + DATA_WIDTH-1], a_i[c*DATA_WIDTH +: DATA_WIDTH]};
        wx = {mode_signed & w_i[(r*COLS+c)*DATA_WIDTH + DATA_WIDTH-1],
              w_i[(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH]};
        prod = ax * wx;
        beat_sum[r] = beat_sum[r] + ACC_WIDTH'(prod);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      mode_signed <= 1'b0;
      for (int unsigned r = 0; r < ROWS; r++) acc[r] <= '0;
    end else if (start_fire) begin
      cnt         <= k_len_i;
      mode_signed <= signed_i;
      for (int unsigned r = 0; r < ROWS; r++) acc[r] <= '0;
    end else if (abort_fire) begin
      cnt <= '0;
      for (int unsigned r = 0; r < ROWS; r++) acc[r] <= '0;
    end else if (beat_fire) begin
      cnt <= cnt - 1'b1;
      for (int unsigned r = 0; r < ROWS; r++) acc[r] <= acc[r] + beat_sum[r];
    end
  end

  always_comb begin
    out_data_o = '0;
    out_sat_o  = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      out_data_o[r*OUT_WIDTH +: OUT_WIDTH] = acc[r][OUT_WIDTH-1:0];
      if (mode_signed) begin
        if ($signed(acc[r]) > $signed(SMAX)) begin
          out_data_o[r*OUT_WIDTH +: OUT_WIDTH] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
          out_sat_o[r] = 1'b1;
        end else if ($signed(acc[r]) < $signed(SMIN)) begin
          out_data_o[r*OUT_WIDTH +: OUT_WIDTH] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
          out_sat_o[r] = 1'b1;
        end
      end else if (acc[r] > UMAX) begin
        out_data_o[r*OUT_WIDTH +: OUT_WIDTH] = '1;
        out_sat_o[r] = 1'b1;
      end
    end
  end

endmodule
